// File: rtl/div_unit.sv
// Execute-stage front end for the 64-bit unsigned iterative divider core (RV64M DIV/REM and W variants).
// Latency: 68 cycles accept-to-out_valid on the core path, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; flush aborts anything in flight.
module div_unit #(
  parameter int DIV_LATENCY = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic          is_word,
  input  logic [63:0]   a,
  input  logic [63:0]   b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          div_valid,
  output logic [63:0]   div_a,
  output logic [63:0]   div_b,
  input  logic [127:0]  div_c
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  localparam logic [6:0] LAT = 7'(DIV_LATENCY);

  state_t        state, state_nx;
  logic [6:0]    cnt;
  logic          neg_q, neg_r, rem_op, word_op;
  logic [127:0]  cap;

  // Accept-time decode
  logic          accept, sgn, sa, sb, b_zero, ovf, special;
  logic [63:0]   ea, eb, ma, mb, min_val, spec_q, spec_r, spec_res;
  // Fix-up datapath
  logic [63:0]   fq, fr, fix_res;

  // W results always take bit 31 as the sign, for signed and unsigned ops alike.
  function automatic logic [63:0] wfix(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Outputs come from state only, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign div_valid = (state == BUSY);

  assign accept = (state == IDLE) && in_valid && !flush;

  // Operand extension, magnitudes and special-case detection for a request in IDLE.
  always_comb begin
    sgn = ~op[0];
    ea  = a;
    eb  = b;
    if (is_word) begin
      ea = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      eb = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end
    sa       = sgn & ea[63];
    sb       = sgn & eb[63];
    ma       = sa ? (~ea + 64'd1) : ea;
    mb       = sb ? (~eb + 64'd1) : eb;
    min_val  = is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    b_zero   = (eb == 64'd0);
    ovf      = sgn && (ea == min_val) && (eb == '1);
    special  = b_zero || ovf;
    spec_q   = b_zero ? '1 : min_val;
    spec_r   = b_zero ? ea : 64'd0;
    spec_res = wfix(is_word, op[1] ? spec_r : spec_q);
  end

  // Sign restoration and result selection from the captured core output.
  always_comb begin
    fq      = neg_q ? (~cap[63:0] + 64'd1) : cap[63:0];
    fr      = neg_r ? (~cap[127:64] + 64'd1) : cap[127:64];
    fix_res = wfix(word_op, rem_op ? fr : fq);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_nx = special ? DONE : BUSY;
        BUSY: if (cnt == LAT) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Cycle counter measuring how long the core has seen div_valid.
  always_ff @(posedge clk) begin
    if (reset || flush)     cnt <= 7'd0;
    else if (state == BUSY) cnt <= (cnt == LAT) ? 7'd0 : cnt + 7'd1;
  end

  // Operand and operation registers, loaded only at accept so the core sees stable inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_a   <= 64'd0;
      div_b   <= 64'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_op  <= 1'b0;
      word_op <= 1'b0;
    end else if (accept) begin
      div_a   <= ma;
      div_b   <= mb;
      neg_q   <= sa ^ sb;
      neg_r   <= sa;
      rem_op  <= op[1];
      word_op <= is_word;
    end
  end

  // Capture the core result on the single cycle it is guaranteed correct.
  always_ff @(posedge clk) begin
    if (reset)                                      cap <= 128'd0;
    else if (state == BUSY && cnt == LAT && !flush) cap <= div_c;
  end

  // Result register: special cases at accept, core results during FIX.
  always_ff @(posedge clk) begin
    if (reset)                         out_data <= 64'd0;
    else if (accept && special)        out_data <= spec_res;
    else if (state == FIX && !flush)   out_data <= fix_res;
  end

endmodule
